// File: rtl/i2c_cmd_master.sv
// i2c_cmd_master: command-driven single-master I2C engine.
// Commands (START, STOP, WRITE, READ_ACK, READ_NACK) are taken over a
// valid/ready handshake and turned into open-drain SCL/SDA waveforms.
// Every bit slot is four phases of PRESCALE clk each.
// Build option: define I2C_CLK_STRETCH_EN to honour slave clock stretching
// (the quarter counter waits at the start of phase 2 while scl_i is low).
module i2c_cmd_master #(
  parameter int PRESCALE = 250,
  parameter int CNT_W    = 16,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              done,
  output logic              ack_nack,
  output logic              cmd_err,
  output logic              bus_owned,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              scl_oe,
  output logic              sda_oe
);

  typedef enum logic [2:0] {IDLE, HOLD, START, STOP, XFER} state_t;

  typedef enum logic [2:0] {
    CMD_START     = 3'd0,
    CMD_STOP      = 3'd1,
    CMD_WRITE     = 3'd2,
    CMD_READ_ACK  = 3'd3,
    CMD_READ_NACK = 3'd4
  } cmd_t;

  state_t            state;
  logic [CNT_W-1:0]  qcnt;
  logic [1:0]        phase;
  logic [4:0]        slot;
  logic              fin;
  logic              is_read;
  logic              rd_nack;
  logic [DATA_W-1:0] txd;
  logic [DATA_W-1:0] rx_shift;
  logic              ack_bit;

  logic hs;
  logic legal;
  logic q_wrap;
  logic last_slot;
  logic stall;

  assign hs        = cmd_valid & cmd_ready;
  assign legal     = (cmd <= CMD_READ_NACK);
  assign q_wrap    = (qcnt == CNT_W'(PRESCALE - 1));
  assign last_slot = (slot == 5'(DATA_W));

`ifdef I2C_CLK_STRETCH_EN
  // Stretch check is made only at the first quarter of phase 2, i.e. right
  // after SCL has been released; a low scl_i there means a slave holds it.
  assign stall = (phase == 2'd2) && (qcnt == '0) && !scl_i;
`else
  logic unused_scl_i;
  assign unused_scl_i = scl_i;
  assign stall = 1'b0;
`endif

  // SDA pull-low enable for a given XFER slot: data bits MSB first, then the
  // ninth (acknowledge) slot.
  function automatic logic slot_sda_oe(input logic [4:0]        s,
                                       input logic              rd,
                                       input logic              nack,
                                       input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] sh;
    sh = d << s;
    if (s == 5'(DATA_W)) return rd ? ~nack : 1'b0;
    return rd ? 1'b0 : ~sh[DATA_W-1];
  endfunction

  // Command FSM, quarter/phase/slot timing and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      qcnt      <= '0;
      phase     <= '0;
      slot      <= '0;
      fin       <= 1'b0;
      is_read   <= 1'b0;
      rd_nack   <= 1'b0;
      txd       <= '0;
      rx_shift  <= '0;
      ack_bit   <= 1'b0;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
      rx_data   <= '0;
      ack_nack  <= 1'b0;
      done      <= 1'b0;
      cmd_err   <= 1'b0;
      bus_owned <= 1'b0;
      cmd_ready <= 1'b0;
    end else begin
      done    <= 1'b0;
      cmd_err <= 1'b0;
      case (state)
        IDLE, HOLD: begin
          cmd_ready <= 1'b1;
          if (hs) begin
            qcnt  <= '0;
            phase <= '0;
            slot  <= '0;
            if (!legal || (state == IDLE && cmd != CMD_START)) begin
              cmd_err <= 1'b1;
            end else begin
              cmd_ready <= 1'b0;
              case (cmd_t'(cmd))
                CMD_START: begin
                  // From HOLD, SCL is already held low and stays so for ph0.
                  state     <= START;
                  bus_owned <= 1'b1;
                  sda_oe    <= 1'b0;
                end
                CMD_STOP: begin
                  state  <= STOP;
                  sda_oe <= 1'b1;
                  scl_oe <= 1'b1;
                end
                default: begin
                  state   <= XFER;
                  is_read <= (cmd != CMD_WRITE);
                  rd_nack <= (cmd == CMD_READ_NACK);
                  txd     <= tx_data;
                  scl_oe  <= 1'b1;
                  sda_oe  <= slot_sda_oe(5'd0, (cmd != CMD_WRITE), 1'b0, tx_data);
                end
              endcase
            end
          end
        end
        default: begin
          // One extra clk after the final phase completes the command and
          // publishes its results together with done.
          if (fin) begin
            fin       <= 1'b0;
            done      <= 1'b1;
            cmd_ready <= 1'b1;
            state     <= (state == STOP) ? IDLE : HOLD;
            if (state == STOP) bus_owned <= 1'b0;
            if (state == XFER) begin
              if (is_read) rx_data  <= rx_shift;
              else         ack_nack <= ack_bit;
            end
          end else if (!stall) begin
            if (q_wrap) begin
              qcnt  <= '0;
              phase <= phase + 2'd1;
            end else begin
              qcnt <= qcnt + CNT_W'(1);
            end
            if (q_wrap) begin
              case (state)
                START: begin
                  case (phase)
                    2'd0: scl_oe <= 1'b0;
                    2'd1: sda_oe <= 1'b1;
                    2'd3: begin
                      scl_oe <= 1'b1;
                      fin    <= 1'b1;
                    end
                    default: ;
                  endcase
                end
                STOP: begin
                  case (phase)
                    2'd0: scl_oe <= 1'b0;
                    2'd2: sda_oe <= 1'b0;
                    2'd3: fin    <= 1'b1;
                    default: ;
                  endcase
                end
                default: begin
                  case (phase)
                    2'd1: scl_oe <= 1'b0;
                    2'd2: begin
                      if (last_slot) ack_bit  <= sda_i;
                      else           rx_shift <= (rx_shift << 1) | DATA_W'(sda_i);
                    end
                    2'd3: begin
                      scl_oe <= 1'b1;
                      if (last_slot) begin
                        fin <= 1'b1;
                      end else begin
                        slot   <= slot + 5'd1;
                        sda_oe <= slot_sda_oe(slot + 5'd1, is_read, rd_nack, txd);
                      end
                    end
                    default: ;
                  endcase
                end
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cmd_master.sv
// tb_i2c_cmd_master: randomized self-checking bench for i2c_cmd_master.
// Open-drain bus is modelled as wired-AND of master, slave and stretcher.
module tb_i2c_cmd_master;

  localparam int P    = 2;
  localparam int DW   = 8;
  localparam int SLOT = 4 * P;
`ifdef I2C_CLK_STRETCH_EN
  localparam int STRETCH_ON = 1;
`else
  localparam int STRETCH_ON = 0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd = 3'd0;
  logic [DW-1:0] tx_data = '0;
  logic [DW-1:0] rx_data;
  logic          done, ack_nack, cmd_err, bus_owned;
  logic          scl_i, sda_i, scl_oe, sda_oe;
  logic          slv_low = 1'b0;
  logic          stretch = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  bit rise_q[$];
  int start_cnt = 0;
  int stop_cnt  = 0;
  bit slave_to  = 0;

  logic [DW-1:0] exp_rx  = '0;
  logic          exp_ack = 1'b0;

  assign scl_i = ~scl_oe & ~stretch;
  assign sda_i = ~sda_oe & ~slv_low;

  i2c_cmd_master #(.PRESCALE(P), .CNT_W(16), .DATA_W(DW)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .tx_data(tx_data), .rx_data(rx_data), .done(done),
    .ack_nack(ack_nack), .cmd_err(cmd_err), .bus_owned(bus_owned),
    .scl_i(scl_i), .sda_i(sda_i), .scl_oe(scl_oe), .sda_oe(sda_oe)
  );

  always #5 clk = ~clk;

  // Bus monitor: START/STOP conditions and the SDA level at each SCL rise.
  initial begin
    logic ps, pd;
    ps = 1'b1;
    pd = 1'b1;
    forever begin
      @(negedge clk);
      if (ps && scl_i) begin
        if (pd && !sda_i) start_cnt++;
        if (!pd && sda_i) stop_cnt++;
      end
      if (!ps && scl_i) rise_q.push_back(sda_i);
      ps = scl_i;
      pd = sda_i;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_cmd(input logic [2:0] c, input logic [DW-1:0] d, output logic err);
    int g;
    g = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL handshake_timeout: cmd_ready=%b required 1", cmd_ready);
    end
    cmd = c;
    tx_data = d;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    err = cmd_err;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 3000; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic wait_scl_fall();
    int g;
    g = 0;
    while (scl_i !== 1'b1 && g < 500) begin @(negedge clk); g++; end
    while (scl_i !== 1'b0 && g < 500) begin @(negedge clk); g++; end
    if (g >= 500) slave_to = 1;
  endtask

  task automatic slave_read(input logic [DW-1:0] v);
    slv_low = ~v[DW-1];
    for (int i = DW - 2; i >= 0; i--) begin
      wait_scl_fall();
      slv_low = ~v[i];
    end
    wait_scl_fall();
    slv_low = 1'b0;
  endtask

  task automatic slave_write(input logic nack);
    repeat (DW) wait_scl_fall();
    slv_low = ~nack;
    wait_scl_fall();
    slv_low = 1'b0;
  endtask

  function automatic logic [DW:0] rise_bits();
    logic [DW:0] r;
    r = '0;
    foreach (rise_q[i]) if (i <= DW) r[DW-i] = rise_q[i];
    return r;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({scl_oe, sda_oe, done, cmd_err, bus_owned, ack_nack, cmd_ready} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 0000000", {scl_oe, sda_oe, done, cmd_err, bus_owned, ack_nack, cmd_ready});
    end
    n_checks++;
    if (rx_data !== '0) begin n_fail++; $display("FAIL reset_rx: got %h required 00", rx_data); end
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL ready_at_release: got %b required 0", cmd_ready); end
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_release: got %b required 1", cmd_ready); end
  endtask

  task automatic test_idle_err(input logic [2:0] c);
    logic err;
    bit bad;
    do_cmd(c, DW'($urandom), err);
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL idle_err_pulse cmd=%0d: got %b required 1", c, err); end
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (cmd_err !== 1'b0 || scl_oe !== 1'b0 || sda_oe !== 1'b0 || done !== 1'b0 ||
          cmd_ready !== 1'b1 || bus_owned !== 1'b0) bad = 1;
    end
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL idle_err_quiet cmd=%0d: activity seen, required none", c); end
  endtask

  task automatic test_hold_err(input logic [2:0] c);
    logic err, sda0;
    bit bad;
    sda0 = sda_oe;
    do_cmd(c, DW'($urandom), err);
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL hold_err_pulse cmd=%0d: got %b required 1", c, err); end
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (cmd_err !== 1'b0 || scl_oe !== 1'b1 || sda_oe !== sda0 || done !== 1'b0 ||
          cmd_ready !== 1'b1 || bus_owned !== 1'b1) bad = 1;
    end
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL hold_err_quiet cmd=%0d: activity seen, required none", c); end
  endtask

  task automatic test_start();
    int s0, p0, lat;
    logic err;
    s0 = start_cnt;
    p0 = stop_cnt;
    do_cmd(3'd0, '0, err);
    n_checks++;
    if (err !== 1'b0 || bus_owned !== 1'b1) begin
      n_fail++; $display("FAIL start_accept: err=%b owned=%b required 0 1", err, bus_owned);
    end
    wait_done(lat);
    n_checks++;
    if (lat != SLOT + 1) begin n_fail++; $display("FAIL start_latency: got %0d required %0d", lat, SLOT + 1); end
    n_checks++;
    if (start_cnt != s0 + 1 || stop_cnt != p0) begin
      n_fail++; $display("FAIL start_cond: starts=%0d stops=%0d required %0d %0d", start_cnt, stop_cnt, s0 + 1, p0);
    end
    n_checks++;
    if (bus_owned !== 1'b1 || cmd_ready !== 1'b1 || scl_oe !== 1'b1) begin
      n_fail++; $display("FAIL start_hold: owned=%b ready=%b scl_oe=%b required 1 1 1", bus_owned, cmd_ready, scl_oe);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width: got %b required 0", done); end
  endtask

  task automatic test_stop();
    int p0, lat;
    logic err;
    p0 = stop_cnt;
    do_cmd(3'd1, '0, err);
    n_checks++;
    if (err !== 1'b0 || bus_owned !== 1'b1) begin
      n_fail++; $display("FAIL stop_accept: err=%b owned=%b required 0 1", err, bus_owned);
    end
    wait_done(lat);
    n_checks++;
    if (lat != SLOT + 1) begin n_fail++; $display("FAIL stop_latency: got %0d required %0d", lat, SLOT + 1); end
    n_checks++;
    if (stop_cnt != p0 + 1 || bus_owned !== 1'b0 || scl_oe !== 1'b0 || sda_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_cond: stops=%0d owned=%b scl_oe=%b sda_oe=%b required %0d 0 0 0", stop_cnt, bus_owned, scl_oe, sda_oe, p0 + 1);
    end
  endtask

  task automatic test_write(input logic [DW-1:0] d, input logic nack);
    int lat;
    logic err;
    logic [DW:0] got;
    rise_q.delete();
    slave_to = 0;
    do_cmd(3'd2, d, err);
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL write_accept: err=%b required 0", err); end
    fork
      slave_write(nack);
      wait_done(lat);
    join
    exp_ack = nack;
    n_checks++;
    if (lat != SLOT * (DW + 1) + 1) begin
      n_fail++; $display("FAIL write_latency: got %0d required %0d", lat, SLOT * (DW + 1) + 1);
    end
    got = rise_bits();
    n_checks++;
    if (rise_q.size() != DW + 1 || got !== {d, nack} || slave_to) begin
      n_fail++; $display("FAIL write_sda_bits: got %b (%0d rises) required %b", got, rise_q.size(), {d, nack});
    end
    n_checks++;
    if (ack_nack !== exp_ack || rx_data !== exp_rx) begin
      n_fail++; $display("FAIL write_results: ack=%b rx=%h required %b %h", ack_nack, rx_data, exp_ack, exp_rx);
    end
  endtask

  task automatic test_read(input logic [DW-1:0] v, input logic nack);
    int lat;
    logic err;
    logic [DW:0] got;
    rise_q.delete();
    slave_to = 0;
    do_cmd(nack ? 3'd4 : 3'd3, DW'($urandom), err);
    n_checks++;
    if (err !== 1'b0 || rx_data !== exp_rx) begin
      n_fail++; $display("FAIL read_accept: err=%b rx=%h required 0 %h", err, rx_data, exp_rx);
    end
    fork
      slave_read(v);
      wait_done(lat);
    join
    exp_rx = v;
    n_checks++;
    if (lat != SLOT * (DW + 1) + 1) begin
      n_fail++; $display("FAIL read_latency: got %0d required %0d", lat, SLOT * (DW + 1) + 1);
    end
    got = rise_bits();
    n_checks++;
    if (rise_q.size() != DW + 1 || got !== {v, nack} || slave_to) begin
      n_fail++; $display("FAIL read_sda_bits: got %b (%0d rises) required %b", got, rise_q.size(), {v, nack});
    end
    n_checks++;
    if (rx_data !== exp_rx || ack_nack !== exp_ack || sda_oe !== ~nack) begin
      n_fail++;
      $display("FAIL read_results: rx=%h ack=%b sda_oe=%b required %h %b %b", rx_data, ack_nack, sda_oe, exp_rx, exp_ack, ~nack);
    end
  endtask

  task automatic test_repeated_start();
    int p0;
    bit dropped;
    p0 = stop_cnt;
    dropped = 0;
    fork
      test_start();
      repeat (SLOT + 1) begin
        @(negedge clk);
        if (bus_owned !== 1'b1) dropped = 1;
      end
    join
    n_checks++;
    if (dropped || stop_cnt != p0) begin
      n_fail++; $display("FAIL rep_start_owned: dropped=%0d stops=%0d required 0 %0d", dropped, stop_cnt, p0);
    end
  endtask

  task automatic test_stretch();
    int lat, exp_lat;
    logic err;
    do_cmd(3'd2, 8'hA5, err);
    fork
      begin
        repeat (2 * SLOT) @(negedge clk);
        stretch = 1'b1;
        repeat (2 * P + 10) @(negedge clk);
        stretch = 1'b0;
      end
      wait_done(lat);
    join
    exp_ack = 1'b1;
    exp_lat = SLOT * (DW + 1) + 1 + 10 * STRETCH_ON;
    n_checks++;
    if (lat != exp_lat || err !== 1'b0) begin
      n_fail++; $display("FAIL stretch_latency: got %0d err=%b required %0d 0", lat, err, exp_lat);
    end
    n_checks++;
    if (ack_nack !== exp_ack) begin n_fail++; $display("FAIL stretch_ack: got %b required %b", ack_nack, exp_ack); end
  endtask

  task automatic test_reset_midread();
    logic err;
    int p0;
    do_cmd(3'd3, '0, err);
    repeat (4 * SLOT + 2) @(negedge clk);
    n_checks++;
    if (scl_oe !== 1'b1) begin n_fail++; $display("FAIL midread_pre: scl_oe=%b required 1", scl_oe); end
    p0 = stop_cnt;
    #2 reset_n = 1'b0;
    #1;
    exp_rx = '0;
    exp_ack = 1'b0;
    n_checks++;
    if (scl_oe !== 1'b0 || sda_oe !== 1'b0 || bus_owned !== 1'b0 || cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midread_async: scl_oe=%b sda_oe=%b owned=%b ready=%b required 0 0 0 0", scl_oe, sda_oe, bus_owned, cmd_ready);
    end
    n_checks++;
    if (rx_data !== exp_rx || ack_nack !== exp_ack) begin
      n_fail++; $display("FAIL midread_clear: rx=%h ack=%b required %h %b", rx_data, ack_nack, exp_rx, exp_ack);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1 || stop_cnt != p0) begin
      n_fail++; $display("FAIL midread_release: ready=%b stops=%0d required 1 %0d", cmd_ready, stop_cnt, p0);
    end
    test_idle_err(3'd2);
    test_start();
    test_stop();
  endtask

  initial begin
    test_reset();
    test_idle_err(3'd2);
    test_idle_err(3'($urandom_range(5, 7)));
    test_start();
    test_write(8'hA5, 1'b0);
    for (int i = 0; i < 3; i++) test_write(DW'($urandom), 1'($urandom_range(0, 1)));
    test_repeated_start();
    test_read(8'h3C, 1'b1);
    test_stop();
    test_idle_err(3'd1);
    test_start();
    for (int i = 0; i < 3; i++) test_read(DW'($urandom), 1'($urandom_range(0, 1)));
    test_hold_err(3'd6);
    test_hold_err(3'($urandom_range(5, 7)));
    test_write(DW'($urandom), 1'($urandom_range(0, 1)));
    test_repeated_start();
    test_stretch();
    test_reset_midread();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
